// File: rtl/amber48_uart_rx.sv
// amber48 UART receiver: 2-flop synchronizer, mid-bit sampling 8N1 deframer,
// and a small first-word-fall-through receive FIFO with sticky error flags.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle high, waiting for a falling edge
// START   | counting to mid start bit, rejects glitches shorter than half a bit
// DATA    | sampling 8 data bits LSB-first, one per bit period
// STOP    | sampling the stop bit; push on high, frame error on low
// BREAK   | line held low after a bad stop bit, wait for it to go high
module amber48_uart_rx #(
    parameter int CLOCK_FREQ_HZ = 27_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       clear_err_i,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("amber48_uart_rx: CLKS_PER_BIT must be at least 4");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("amber48_uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    logic          rx_meta_q;
    logic          rx_s_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_req;
    logic          frame_set;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          frame_err_q, overrun_q;
    logic          full, empty, pop, push_ok, overrun_set;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    cnt_d              = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && ready_i;
    // A pop in the same cycle frees the slot being written, so full is not a blocker.
    assign push_ok     = push_req && (!full || pop);
    assign overrun_set = push_req && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
            if (frame_set) begin
                frame_err_q <= 1'b1;
            end else if (clear_err_i) begin
                frame_err_q <= 1'b0;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clear_err_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign data_o      = mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o     = !empty;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_amber48_uart_rx.sv
// Bench for amber48_uart_rx: directed frames plus random traffic, with received
// bytes checked by a scoreboard monitor against a capacity-limited queue model.
module tb_amber48_uart_rx;

    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       clear_err_i;
    logic       busy_o;

    logic       ready_cmd = 1'b0;
    logic       ready_rnd = 1'b0;
    logic       rand_mode = 1'b0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;

    assign ready_i = rand_mode ? ready_rnd : ready_cmd;

    amber48_uart_rx #(
        .CLOCK_FREQ_HZ(16),
        .BAUD_RATE    (1),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .clear_err_i(clear_err_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        #1;
        ready_rnd = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // A byte leaves the DUT on every cycle with valid && ready; it must match the oldest queued byte.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %02h, expected no byte", data_o);
            end else begin
                mon_exp = sb.pop_front();
                chk("pop_data", int'(data_o), int'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_flags(input string name);
        chk({name, "_frame_err"}, int'(frame_err_o), int'(exp_ferr));
        chk({name, "_overrun"}, int'(overrun_o), int'(exp_ovr));
    endtask

    task automatic clear_flags();
        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // Entered just after a clock edge; returns 160 cycles later, mid stop bit + half.
    // The stop sample lands 155 edges after the start bit is driven.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit clr_at_stop, input bit rdy_at_stop);
        rx_i = 1'b0;
        repeat (16) tick();
        for (int k = 0; k < 8; k++) begin
            rx_i = b[k];
            repeat (16) tick();
        end
        rx_i = stop_bit;
        repeat (10) tick();
        if (clr_at_stop) clear_err_i = 1'b1;
        if (rdy_at_stop) ready_cmd = 1'b1;
        tick();
        clear_err_i = 1'b0;
        if (rdy_at_stop) ready_cmd = 1'b0;
        if (clr_at_stop) begin
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end
        if (stop_bit) begin
            if (sb.size() < DEPTH) sb.push_back(b);
            else exp_ovr = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
        repeat (5) tick();
    endtask

    task automatic drain(input string name);
        int n;
        ready_cmd = 1'b1;
        n = 0;
        while (valid_o && n < 200) begin
            tick();
            n++;
        end
        ready_cmd = 1'b0;
        chk({name, "_drain_timeout"}, int'(n >= 200), 0);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        bit         seen;
        logic [7:0] b;
        bit         good;

        rst_ni      = 1'b0;
        rx_i        = 1'b1;
        clear_err_i = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        check_flags("reset");
        repeat (5) tick();

        // single byte, held in the FIFO until a one-cycle pop
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("single_valid", int'(valid_o), 1);
        chk("single_data", int'(data_o), 8'hA5);
        check_flags("single");
        ready_cmd = 1'b1;
        tick();
        ready_cmd = 1'b0;
        chk("single_valid_after_pop", int'(valid_o), 0);

        // glitch shorter than half a bit
        repeat (5) tick();
        rx_i = 1'b0;
        repeat (5) tick();
        rx_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy_o) seen = 1'b1;
            tick();
        end
        chk("glitch_busy_seen", int'(seen), 1);
        chk("glitch_busy_end", int'(busy_o), 0);
        chk("glitch_valid", int'(valid_o), 0);
        check_flags("glitch");

        // framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) tick();
        chk("break_busy", int'(busy_o), 1);
        chk("break_valid", int'(valid_o), 0);
        check_flags("ferr");
        rx_i = 1'b1;
        repeat (4) tick();
        chk("break_release_busy", int'(busy_o), 0);
        ready_cmd = 1'b1;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        ready_cmd = 1'b0;
        chk("after_ferr_sb_empty", sb.size(), 0);
        clear_flags();
        check_flags("ferr_cleared");

        // overrun: five back-to-back frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        check_flags("overrun");
        drain("overrun");
        clear_flags();

        // refill, then pop exactly on the fifth stop sample
        for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1, 1'b0, 1'b0);
        send_frame(8'h25, 1'b1, 1'b0, 1'b1);
        check_flags("push_pop_same_cycle");
        chk("push_pop_valid", int'(valid_o), 1);
        drain("push_pop");

        // reset during data bit 3 with the line low
        rx_i = 1'b0;
        repeat (16) tick();
        rx_i = 1'b1; repeat (16) tick();
        rx_i = 1'b0; repeat (16) tick();
        rx_i = 1'b1; repeat (16) tick();
        rx_i = 1'b0; repeat (8) tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        rx_i   = 1'b1;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        chk("midreset_valid", int'(valid_o), 0);
        chk("midreset_busy", int'(busy_o), 0);
        check_flags("midreset");
        repeat (20) tick();
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        chk("midreset_next_data", int'(data_o), 8'h7E);
        drain("midreset");

        // error clear, then clear colliding with a new framing error
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        rx_i = 1'b1;
        repeat (4) tick();
        check_flags("clr_pre");
        clear_flags();
        check_flags("clr_done");
        repeat (4) tick();
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        chk("set_wins_frame_err", int'(frame_err_o), 1);
        check_flags("set_wins");
        rx_i = 1'b1;
        repeat (4) tick();
        clear_flags();

        // random traffic with random ready
        rand_mode = 1'b1;
        for (int f = 0; f < 24; f++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 7) != 0);
            send_frame(b, good, ($urandom_range(0, 5) == 0), 1'b0);
            if (!good) begin
                repeat ($urandom_range(0, 30)) tick();
                rx_i = 1'b1;
                repeat (4) tick();
            end
            repeat ($urandom_range(0, 12)) tick();
            check_flags("random");
        end
        rand_mode = 1'b0;
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/amber48_uart_rx.md
# amber48_uart_rx

UART receiver for the amber48 SoC: oversamples the asynchronous `rx_i` line, deframes 8N1 characters LSB-first, and queues received bytes in a small first-word-fall-through FIFO. It is the receive-side counterpart of `amber48_uart_tx` and sits upstream of `amber48_dmem`. The MMIO decoder drains bytes via a valid/ready pop and reads the sticky error flags.

## Interface
- `CLOCK_FREQ_HZ`, default 27_000_000: core clock frequency.
- `BAUD_RATE`, default 115_200: line rate.
- `FIFO_DEPTH`, default 4: receive queue entries; power of two, ≥2.
- Derived: `CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE` (integer division; 234 at defaults); `HALF_BIT = CLKS_PER_BIT / 2` (117). Elaboration error if `CLKS_PER_BIT < 4`.

Ports:
- `clk_i`  in  1  core clock; the only clock.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `rx_i`  in  1  asynchronous serial input; idle high.
- `data_o`  out  8  FIFO head byte; valid only while `valid_o`=1.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  pop: the head is consumed on any cycle with `valid_o && ready_i`.
- `frame_err_o`  out  1  sticky: a stop bit was sampled low.
- `overrun_o`  out  1  sticky: a good byte was dropped because the FIFO was full.
- `clear_err_i`  in  1  one-cycle pulse that clears both sticky flags.
- `busy_o`  out  1  FSM not in IDLE.

## Operation
- Synchronizer: two flops on `rx_i`, both reset to 1. All FSM decisions use the second flop (`rx_s`).
- Bit counter: `cnt` spans 0..`CLKS_PER_BIT`-1. Bit index: `bit_idx` spans 0..7. Shift register: `shift`, 8 bits, filled LSB-first.
- FSM states and transitions:
  - IDLE: when `rx_s`=0, set `cnt`=0 and go to START.
  - START: when `cnt`=`HALF_BIT`-1, sample `rx_s`.
    - `rx_s`=1 (glitch): go to IDLE, nothing recorded.
    - `rx_s`=0: set `cnt`=0, `bit_idx`=0, go to DATA.
  - DATA: when `cnt`=`CLKS_PER_BIT`-1, shift `rx_s` into `shift[bit_idx]` and clear `cnt`. After bit 7, go to STOP.
  - STOP: when `cnt`=`CLKS_PER_BIT`-1, sample `rx_s`.
    - `rx_s`=1: push `shift` into the FIFO and go to IDLE.
    - `rx_s`=0: set `frame_err_o`, discard the byte, go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from re-triggering start detection.
- Sampling position: START samples mid-bit; each later sample falls one full bit period after the previous one, so every data and stop sample is also mid-bit.
- FIFO:
  - Circular buffer with read and write pointers of log2(`FIFO_DEPTH`)+1 bits.
  - full = (MSBs differ and the remaining bits are equal); empty = (pointers equal).
  - `data_o` = mem[rd_ptr], combinational; `valid_o` = !empty.
- Push rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overrun_o` is set. FIFO contents are unchanged.
- Pop: on `valid_o && ready_i`, increment `rd_ptr`. With `valid_o`=0, `ready_i` has no effect.
- Error flags:
  - `clear_err_i` clears both flags.
  - A set event and a clear in the same cycle leave the flag set (set wins).
- Reset: pointers return to 0 (FIFO empty). The FSM returns to IDLE and `cnt`/`bit_idx` clear. A frame in progress is abandoned with no push and no error.

## Timing
- Reset values: `valid_o`=0, `data_o`=mem[0] (don't-care), `frame_err_o`=0, `overrun_o`=0, `busy_o`=0. Synchronizer flops reset to 1.
- Input to FSM: a falling edge on `rx_i` reaches `rx_s` 2 cycles later. The FSM leaves IDLE on the following edge.
- Push timing: a push occurs on the clock edge of the stop-bit sample, so `valid_o` rises the next cycle.
  - With `rx_i` ideal, this is about 9.5 bit periods + 3 cycles after the start-bit falling edge.
- Pop timing: registered. `valid_o`/`data_o` reflect the pop on the next cycle.
- Back-to-back frames: STOP returns to IDLE mid-stop-bit, so a start bit immediately following the stop bit is detected. There is no dead time requirement.
- Flag timing: `frame_err_o` and `overrun_o` assert the cycle after the stop-bit sample.

## Test plan
Bench parameters unless noted: `CLOCK_FREQ_HZ`=16, `BAUD_RATE`=1, so `CLKS_PER_BIT`=16.

1. Single byte: drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), hold `ready_i`=0.
   - Required: `valid_o`=1 with `data_o`=0xA5 after the stop sample. Both flags stay 0.
   - Then pulse `ready_i`: `valid_o`=0 the next cycle.
2. Glitch rejection: drive `rx_i` low for 5 cycles (less than `HALF_BIT`=8), then high.
   - Required: `busy_o` pulses and then returns to 0. `valid_o` stays 0. No flags set.
3. Framing error: drive 0x3C with the stop bit low, then hold low for 40 cycles, then release high.
   - Required: `frame_err_o`=1 and no push. `busy_o` stays 1 until the line goes high.
   - Then a good 0x11 frame is received correctly.
4. Overrun and simultaneous push/pop: `FIFO_DEPTH`=4, `ready_i`=0.
   - Send 0x01–0x05 back-to-back. Required: `overrun_o`=1; pops return 0x01–0x04 only.
   - Refill to full, then assert `ready_i` exactly on the 5th stop-sample cycle. Required: no overrun; the 5th byte is queued.
5. Reset mid-frame: assert `rst_ni`=0 for 1 cycle during data bit 3, with the line still low.
   - Required: all outputs at reset values. Line-high idle followed by a new 0x7E frame receives 0x7E only.
6. Error clear: with `frame_err_o`=1, pulse `clear_err_i` → flag 0.
   - Then pulse `clear_err_i` on the same cycle as a new framing-error stop sample. Required: flag 1 (set wins).
